mem_port_arbiter: RTL and testbench

//  Shares the single byte-addressed 32-bit data memory between two requesters:

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the shared MIPS data memory.
// Fixed wait states per access, one-cycle ack, misaligned word accesses rejected.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_din,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_dout,
    output logic          err,
    output logic          busy
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] wcnt;
    logic          port;
    logic          we_q;
    logic          mis_q;
    logic          rr_last;
    logic          grant;
    logic          last;

    logic          win;
    logic [AW-1:0] g_adr;
    logic [DW-1:0] g_wdata;
    logic          g_we;
    logic          g_mis;

    // On a tie the port that did not win last time is served.
    assign win     = (req0 && req1) ? !rr_last : req1;
    assign g_adr   = win ? adr1 : adr0;
    assign g_wdata = win ? wdata1 : wdata0;
    assign g_we    = win ? we1 : we0;
    assign g_mis   = (g_adr[1:0] != 2'b00);
    assign last    = (wcnt == '0);
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        err     = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    state_n = g_mis ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_rd = !we_q;
                mem_wr = we_q && last;
                if (last) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                ack0    = !port;
                ack1    = port;
                err     = mis_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            port    <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            rr_last <= 1'b1;
            mem_adr <= '0;
            mem_din <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                port    <= win;
                we_q    <= g_we;
                mis_q   <= g_mis;
                rr_last <= win;
                wcnt    <= CW'(WAIT_CYCLES - 1);
                // The memory bus is only touched for accesses that will run.
                if (!g_mis) begin
                    mem_adr <= g_adr;
                    if (g_we) begin
                        mem_din <= g_wdata;
                    end
                end else if (win) begin
                    rdata1 <= '0;
                end else begin
                    rdata0 <= '0;
                end
            end
            if (state == ACCESS) begin
                if (!last) begin
                    wcnt <= wcnt - 1'b1;
                end else if (!we_q) begin
                    if (port) begin
                        rdata1 <= mem_dout;
                    end else begin
                        rdata0 <= mem_dout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: WAIT_CYCLES=1 and 3 instances
// checked every cycle against a transaction-level timing model.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  req0, we0, req1, we1;
    logic [1:0]  ack0, ack1, mem_rd, mem_wr, err, busy;
    logic [31:0] adr0[2], wdata0[2], adr1[2], wdata1[2];
    logic [31:0] rdata0[2], rdata1[2];
    logic [31:0] mem_adr[2], mem_din[2], mem_dout[2];

    logic        rq[2][2];
    logic        rwe[2][2];
    logic [31:0] radr[2][2];
    logic [31:0] rdat[2][2];
    logic [31:0] mem[2][256];

    for (genvar d = 0; d < 2; d++) begin : g_map
        assign req0[d]     = rq[d][0];
        assign req1[d]     = rq[d][1];
        assign we0[d]      = rwe[d][0];
        assign we1[d]      = rwe[d][1];
        assign adr0[d]     = radr[d][0];
        assign adr1[d]     = radr[d][1];
        assign wdata0[d]   = rdat[d][0];
        assign wdata1[d]   = rdat[d][1];
        assign mem_dout[d] = mem[d][mem_adr[d][9:2]];
    end

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst[0]),
        .req0(req0[0]), .we0(we0[0]), .adr0(adr0[0]), .wdata0(wdata0[0]),
        .ack0(ack0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .adr1(adr1[0]), .wdata1(wdata1[0]),
        .ack1(ack1[0]), .rdata1(rdata1[0]),
        .mem_adr(mem_adr[0]), .mem_din(mem_din[0]), .mem_rd(mem_rd[0]),
        .mem_wr(mem_wr[0]), .mem_dout(mem_dout[0]),
        .err(err[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst[1]),
        .req0(req0[1]), .we0(we0[1]), .adr0(adr0[1]), .wdata0(wdata0[1]),
        .ack0(ack0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .adr1(adr1[1]), .wdata1(wdata1[1]),
        .ack1(ack1[1]), .rdata1(rdata1[1]),
        .mem_adr(mem_adr[1]), .mem_din(mem_din[1]), .mem_rd(mem_rd[1]),
        .mem_wr(mem_wr[1]), .mem_dout(mem_dout[1]),
        .err(err[1]), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one transaction in flight per instance.
    int          e;
    int          nxt[2], tack[2], tg[2];
    logic        act[2], rr[2], tp[2], twe[2], terr[2];
    logic [31:0] ta[2], tdat[2], trd[2];
    logic [31:0] exp_rd[2][2];
    logic [31:0] refm[2][256];
    logic        gnt[2][2], pend[2][2];
    int          si[2][2];
    bit          stop;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic txn_t scr(input int p, input int i);
        txn_t t;
        t = '0;
        if (p == 0) begin
            t.adr = (i == 0) ? 32'h100 : 32'h200;
        end else if (i == 0) begin
            t.we  = 1'b1;
            t.adr = 32'h200;
            t.dat = 32'h1234_5678;
        end else begin
            t.adr = 32'h102;
        end
        return t;
    endfunction

    task automatic issue(input int d, input int p);
        txn_t        t;
        int unsigned word, off;
        if (si[d][p] < 2) begin
            t = scr(p, si[d][p]);
            si[d][p]++;
        end else begin
            word  = $urandom_range(255, 0);
            off   = ($urandom_range(7, 0) == 0) ? $urandom_range(3, 1) : 0;
            t.adr = (word << 2) | off;
            t.we  = 1'($urandom_range(1, 0));
            t.dat = $urandom;
        end
        rq[d][p]   = 1'b1;
        rwe[d][p]  = t.we;
        radr[d][p] = t.adr;
        rdat[d][p] = t.dat;
        pend[d][p] = 1'b1;
    endtask

    // Grant decision and timing for a request seen at this edge.
    task automatic model_edge();
        logic w;
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                act[d]       = 1'b0;
                nxt[d]       = e + 1;
                rr[d]        = 1'b1;
                exp_rd[d][0] = '0;
                exp_rd[d][1] = '0;
                gnt[d][0]    = 1'b0;
                gnt[d][1]    = 1'b0;
            end else if (e == nxt[d]) begin
                if (rq[d][0] || rq[d][1]) begin
                    w          = (rq[d][0] && rq[d][1]) ? !rr[d] : rq[d][1];
                    rr[d]      = w;
                    act[d]     = 1'b1;
                    tp[d]      = w;
                    ta[d]      = radr[d][w];
                    twe[d]     = rwe[d][w];
                    tdat[d]    = rdat[d][w];
                    terr[d]    = (ta[d][1:0] != 2'b00);
                    tg[d]      = e;
                    trd[d]     = refm[d][ta[d][9:2]];
                    gnt[d][w]  = 1'b1;
                    tack[d]    = e + 1 + (terr[d] ? 0 : wc(d));
                    nxt[d]     = tack[d] + 1;
                end else begin
                    nxt[d] = e + 1;
                end
            end
        end
        e++;
    endtask

    task automatic check_cycle();
        logic  dn, xrd, xwr;
        string pf;
        for (int d = 0; d < 2; d++) begin
            if (mem_wr[d]) mem[d][mem_adr[d][9:2]] = mem_din[d];
            if (rst[d]) begin
                pf = $sformatf("w%0d ", wc(d));
                dn = act[d] && (e == tack[d]);
                if (dn) begin
                    if (terr[d]) exp_rd[d][tp[d]] = '0;
                    else if (!twe[d]) exp_rd[d][tp[d]] = trd[d];
                    else refm[d][ta[d][9:2]] = tdat[d];
                end
                xrd = act[d] && !terr[d] && !twe[d] && (e > tg[d]) && (e <= tg[d] + wc(d));
                xwr = act[d] && !terr[d] && twe[d] && (e == tg[d] + wc(d));
                chk({pf, "ack0"}, ack0[d], dn && !tp[d]);
                chk({pf, "ack1"}, ack1[d], dn && tp[d]);
                chk({pf, "err"}, err[d], dn && terr[d]);
                chk({pf, "busy"}, busy[d], act[d]);
                chk({pf, "mem_rd"}, mem_rd[d], xrd);
                chk({pf, "mem_wr"}, mem_wr[d], xwr);
                if (xrd || xwr) chk({pf, "mem_adr"}, mem_adr[d], ta[d]);
                if (xwr) chk({pf, "mem_din"}, mem_din[d], tdat[d]);
                chk({pf, "rdata0"}, rdata0[d], exp_rd[d][0]);
                chk({pf, "rdata1"}, rdata1[d], exp_rd[d][1]);
                if (dn) begin
                    act[d]         = 1'b0;
                    pend[d][tp[d]] = 1'b0;
                    rq[d][tp[d]]   = 1'b0;
                    gnt[d][tp[d]]  = 1'b0;
                end
            end
        end
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (rst[d]) begin
                    if (!pend[d][p]) begin
                        if (si[d][p] < 2 || $urandom_range(2, 0) == 0) issue(d, p);
                    end else if (gnt[d][p] && rq[d][p] && $urandom_range(3, 0) == 0) begin
                        rq[d][p] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
        if (!stop) drive();
    endtask

    task automatic reset_zero(input int d);
        string pf;
        pf = $sformatf("rst w%0d ", wc(d));
        chk({pf, "ack0"}, ack0[d], 1'b0);
        chk({pf, "ack1"}, ack1[d], 1'b0);
        chk({pf, "err"}, err[d], 1'b0);
        chk({pf, "busy"}, busy[d], 1'b0);
        chk({pf, "mem_rd"}, mem_rd[d], 1'b0);
        chk({pf, "mem_wr"}, mem_wr[d], 1'b0);
        chk({pf, "mem_adr"}, mem_adr[d], 32'h0);
        chk({pf, "mem_din"}, mem_din[d], 32'h0);
        chk({pf, "rdata0"}, rdata0[d], 32'h0);
        chk({pf, "rdata1"}, rdata1[d], 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        int          bad;
        rst  = 2'b00;
        stop = 1'b0;
        e    = 0;
        for (int d = 0; d < 2; d++) begin
            nxt[d] = 0;
            act[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                rq[d][p]   = 1'b0;
                rwe[d][p]  = 1'b0;
                radr[d][p] = '0;
                rdat[d][p] = '0;
                pend[d][p] = 1'b0;
                gnt[d][p]  = 1'b0;
                si[d][p]   = 0;
            end
            for (int i = 0; i < 256; i++) begin
                v = (i == 64) ? 32'hDEAD_BEEF : $urandom;
                mem[d][i]  = v;
                refm[d][i] = v;
            end
        end

        repeat (3) cycle();
        reset_zero(0);
        reset_zero(1);
        rst = 2'b11;
        drive();

        repeat (3000) cycle();

        stop = 1'b1;
        for (int i = 0; i < 60 && (act[0] || act[1] || pend[0][0] || pend[0][1]
                                   || pend[1][0] || pend[1][1]); i++) cycle();
        chk("drain", {act[0], act[1]}, 2'b00);

        // Write on the 3-wait instance abandoned by reset mid-access.
        rq[1][0]   = 1'b1;
        rwe[1][0]  = 1'b1;
        radr[1][0] = 32'h40;
        rdat[1][0] = 32'hA5A5_5A5A;
        for (int i = 0; i < 5 && !act[1]; i++) cycle();
        chk("abort grant", act[1], 1'b1);
        cycle();
        rst[1]   = 1'b0;
        rq[1][0] = 1'b0;
        cycle();
        reset_zero(1);
        rst[1] = 1'b1;
        repeat (4) cycle();

        for (int d = 0; d < 2; d++) begin
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[d][i] !== refm[d][i]) bad++;
            chk($sformatf("w%0d memory words", wc(d)), bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
